// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the convolution MAC path (fp_mul, fp_acc).
// Fields, significand width with guard bits, accumulator FSM states.
package fp_pkg;

    localparam int EXP_WIDTH = 8;
    localparam int MAN_WIDTH = 23;
    localparam int BIAS      = 127;
    localparam int SIG_WIDTH = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ADD   = 2'd2,
        ST_NORM  = 2'd3
    } acc_state_t;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [MAN_WIDTH-1:0] man;
    } fp32_t;

    // Leading-zero count of a 27-bit significand; 27 when the value is zero.
    function automatic logic [4:0] lzc27(input logic [SIG_WIDTH-1:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < SIG_WIDTH; i++) begin
            if (v[i]) lzc27 = 5'(SIG_WIDTH - 1 - i);
        end
    endfunction

endpackage

// File: rtl/fp_acc_fifo.sv
// Input term buffer: synchronous FIFO, head visible combinationally from the array.
// A push while full is accepted only when a pop happens in the same cycle.
module fp_acc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fp_acc.sv
// Streaming FP32 accumulator: buffered terms are summed by a 3-cycle
// ALIGN/ADD/NORM datapath; every NUM_TERMS terms the sum is emitted and cleared.
module fp_acc
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TERMS  = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  valid_out,
    output logic                  overflow
);

    localparam logic [15:0] LAST_TERM = 16'(NUM_TERMS - 1);

    acc_state_t            state_reg, state_next;
    logic                  pop;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    logic [DATA_WIDTH-1:0] acc_reg, b_reg, out_reg;
    logic                  valid_out_reg, overflow_reg;
    logic [15:0]           count_reg;
    logic [SIG_WIDTH-1:0]  x_sig_reg, y_sig_reg;
    logic [EXP_WIDTH-1:0]  x_exp_reg;
    logic                  x_sign_reg, sub_reg;
    logic [SIG_WIDTH:0]    sum_reg;

    fp_acc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (valid_in),
        .pop       (pop),
        .push_data (in_data),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_ALIGN;
                end
            end
            ST_ALIGN: state_next = ST_ADD;
            ST_ADD:   state_next = ST_NORM;
            ST_NORM: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_ALIGN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Alignment: X is the larger magnitude by {exp,man}; Y is shifted down to X's exponent.
    fp32_t                acc_f, b_f, x_f, y_f;
    logic [SIG_WIDTH-1:0] x_sig, y_sig, y_aligned;
    logic [EXP_WIDTH-1:0] exp_diff;

    always_comb begin
        acc_f = fp32_t'(acc_reg);
        b_f   = fp32_t'(b_reg);
        if (acc_reg[30:0] >= b_reg[30:0]) begin
            x_f = acc_f;
            y_f = b_f;
        end else begin
            x_f = b_f;
            y_f = acc_f;
        end
        x_sig     = (x_f.exp == '0) ? '0 : {1'b1, x_f.man, 3'b000};
        y_sig     = (y_f.exp == '0) ? '0 : {1'b1, y_f.man, 3'b000};
        exp_diff  = x_f.exp - y_f.exp;
        y_aligned = (exp_diff >= 8'd27) ? '0 : (y_sig >> exp_diff);
    end

    // Normalisation: carry shifts right once, otherwise shift out leading zeros.
    logic [4:0]           lz;
    logic signed [9:0]    norm_exp;
    logic [MAN_WIDTH-1:0] norm_man;
    logic [SIG_WIDTH-1:0] norm_shifted;
    logic [31:0]          norm_result;

    always_comb begin
        lz           = lzc27(sum_reg[SIG_WIDTH-1:0]);
        norm_shifted = sum_reg[SIG_WIDTH-1:0] << lz;
        if (sum_reg[SIG_WIDTH]) begin
            norm_man = sum_reg[26:4];
            norm_exp = $signed({2'b00, x_exp_reg}) + 10'sd1;
        end else begin
            norm_man = 23'(norm_shifted >> 3);
            norm_exp = $signed({2'b00, x_exp_reg}) - $signed({5'b00000, lz});
        end
        if (sum_reg == '0 || norm_exp <= 10'sd0)
            norm_result = '0;
        else if (norm_exp >= 10'sd255)
            norm_result = {x_sign_reg, 8'hFE, 23'h7FFFFF};
        else
            norm_result = {x_sign_reg, norm_exp[7:0], norm_man};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            b_reg         <= '0;
            out_reg       <= '0;
            valid_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            count_reg     <= '0;
            x_sig_reg     <= '0;
            y_sig_reg     <= '0;
            x_exp_reg     <= '0;
            x_sign_reg    <= 1'b0;
            sub_reg       <= 1'b0;
            sum_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            valid_out_reg <= 1'b0;
            if (valid_in && fifo_full && !pop) overflow_reg <= 1'b1;
            if (pop) b_reg <= fifo_head;
            case (state_reg)
                ST_ALIGN: begin
                    x_sig_reg  <= x_sig;
                    y_sig_reg  <= y_aligned;
                    x_exp_reg  <= x_f.exp;
                    x_sign_reg <= x_f.sign;
                    sub_reg    <= x_f.sign ^ y_f.sign;
                end
                ST_ADD: begin
                    sum_reg <= sub_reg ? ({1'b0, x_sig_reg} - {1'b0, y_sig_reg})
                                       : ({1'b0, x_sig_reg} + {1'b0, y_sig_reg});
                end
                ST_NORM: begin
                    if (count_reg == LAST_TERM) begin
                        out_reg       <= norm_result;
                        valid_out_reg <= 1'b1;
                        acc_reg       <= '0;
                        count_reg     <= '0;
                    end else begin
                        acc_reg   <= norm_result;
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out       = out_reg;
    assign valid_out = valid_out_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_fp_acc.sv
// Scoreboard bench for fp_acc: an abstract occupancy/timing model plus an
// arithmetic reference adder predict every sum and the cycle it appears in.
module tb_fp_acc;

    localparam int NT    = 3;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] in_data;
    logic [31:0] out;
    logic        valid_out;
    logic        overflow;

    always #5 clk = ~clk;

    fp_acc #(.DATA_WIDTH(32), .NUM_TERMS(NT), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .in_data   (in_data),
        .out       (out),
        .valid_out (valid_out),
        .overflow  (overflow)
    );

    typedef struct {
        logic [31:0] data;
        longint      at;
        logic        has_lit;
        logic [31:0] lit;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    exp_t        exp_q[$];
    logic [31:0] lit_q[$];
    logic [31:0] m_q[$];
    longint      m_ready;
    logic [31:0] m_acc;
    int          m_cnt;
    logic        m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference adder: real-valued significands as integers, shifted with division.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        longint      sx, sy, s;
        int          ex, ey, d;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sx = (ex == 0) ? 0 : (longint'(x[22:0]) + 64'd8388608) * 8;
        sy = (ey == 0) ? 0 : (longint'(y[22:0]) + 64'd8388608) * 8;
        d  = ex - ey;
        sy = (d >= 27) ? 0 : sy / (longint'(1) << d);
        s  = (x[31] == y[31]) ? sx + sy : sx - sy;
        if (s == 0) return 32'h0;
        if (s >= (longint'(1) << 27)) begin
            s  = s / 2;
            ex = ex + 1;
        end else begin
            while (s < (longint'(1) << 26)) begin
                s  = s * 2;
                ex = ex - 1;
            end
        end
        if (ex <= 0)   return 32'h0;
        if (ex >= 255) return {x[31], 8'hFE, 23'h7FFFFF};
        return {x[31], 8'(ex), 23'((s / 8) % 64'd8388608)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        lit_q.delete();
        m_ready = 0;
        m_acc   = 32'h0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
    endtask

    // One clock cycle of stimulus; the model pops when a term is buffered and the
    // adder can take it (at most once per 3 cycles), and result shows 4 cycles later.
    task automatic drive_cycle(input logic v, input logic [31:0] d);
        logic        popm;
        logic [31:0] t;
        exp_t        e;
        valid_in = v;
        in_data  = d;
        popm = (m_q.size() > 0) && (cyc >= m_ready);
        if (popm) begin
            t       = m_q.pop_front();
            m_ready = cyc + 3;
            m_acc   = ref_add(m_acc, t);
            m_cnt++;
            if (m_cnt == NT) begin
                e.data    = m_acc;
                e.at      = cyc + 4;
                e.has_lit = (lit_q.size() > 0);
                e.lit     = e.has_lit ? lit_q.pop_front() : 32'h0;
                exp_q.push_back(e);
                m_acc = 32'h0;
                m_cnt = 0;
            end
        end
        if (v) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check("overflow_flag", {31'b0, overflow}, {31'b0, m_ovf});
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_q.size() > 0 || exp_q.size() > 0) && guard < 400) begin
            drive_cycle(1'b0, 32'h0);
            guard++;
        end
        n_checks++;
        if (guard >= 400) begin
            n_fail++;
            $display("FAIL drain_timeout: actual %0d pending sums required 0", exp_q.size());
        end
        repeat (5) drive_cycle(1'b0, 32'h0);
    endtask

    task automatic group3(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] lit);
        lit_q.push_back(lit);
        drive_cycle(1'b1, a); repeat (3) drive_cycle(1'b0, 32'h0);
        drive_cycle(1'b1, b); repeat (3) drive_cycle(1'b0, 32'h0);
        drive_cycle(1'b1, c); repeat (3) drive_cycle(1'b0, 32'h0);
        drain();
    endtask

    function automatic logic [31:0] rand_term();
        logic [7:0] e;
        e = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'(120 + $urandom_range(0, 15));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Monitor: every valid_out must match the oldest predicted sum, value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid_out: actual out %h required no pulse (cycle %0d)", out, cyc);
            end else begin
                e = exp_q.pop_front();
                check("sum_model", out, e.data);
                if (e.has_lit) check("sum_literal", out, e.lit);
                n_checks++;
                if (cyc != e.at) begin
                    n_fail++;
                    $display("FAIL sum_cycle: actual cycle %0d required %0d", cyc, e.at);
                end
                $display("sum out=%h cycle=%0d", out, cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        in_data  = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out, 32'h0);
        check("reset_valid_out", {31'b0, valid_out}, 32'h0);
        check("reset_overflow", {31'b0, overflow}, 32'h0);
        reset = 1'b0;

        group3(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40C00000);
        group3(32'h3F800000, 32'hBF800000, 32'h00000000, 32'h00000000);
        group3(32'h40400000, 32'hBFC00000, 32'h00000000, 32'h3FC00000);
        group3(32'h3F800000, 32'h30800000, 32'h00000000, 32'h3F800000);
        group3(32'h00000001, 32'h3F800000, 32'h00000000, 32'h3F800000);
        group3(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h7F7FFFFF);
        group3(32'h00800001, 32'h80800000, 32'h00000000, 32'h00000000);

        // Burst of nine ones: three sums of 3.0 at t+11, t+20, t+29.
        repeat (3) lit_q.push_back(32'h40400000);
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 32'h3F800000);
        drain();
        check("burst_no_overflow", {31'b0, overflow}, 32'h0);

        // Sixteen back-to-back terms: overflow from the 13th push; 13 terms survive.
        repeat (4) lit_q.push_back(32'h40400000);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 32'h3F800000);
            check("overflow_onset", {31'b0, overflow}, (i >= 12) ? 32'h1 : 32'h0);
        end
        drain();

        // Reset while the datapath is in ADD with four terms buffered.
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 32'h3F800000);
        valid_in = 1'b0;
        reset    = 1'b1;
        #1;
        check("midrun_reset_out", out, 32'h0);
        check("midrun_reset_valid_out", {31'b0, valid_out}, 32'h0);
        check("midrun_reset_overflow", {31'b0, overflow}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        group3(32'h40000000, 32'h40800000, 32'h3F800000, 32'h40E00000);

        // Randomised traffic, light enough that the FIFO rarely fills.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) drive_cycle(1'b1, rand_term());
            else drive_cycle(1'b0, 32'h0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
